wc_tile_gen: RTL and testbench
==============================

WC_TILE_GEN -- requirements
Module: wc_tile_gen

Interface
REQ-001 SHALL have parameter DW, default 10, sample width in bits (two's complement).
REQ-002 SHALL have parameter TILE, default 5, samples per tile; fixed at 5 for F(3,3).
REQ-003 SHALL have parameter STRIDE, default 3, new samples per tile after the first; fixed at 3.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port din, input, DW, the input sample stream.
REQ-007 SHALL have port din_valid, input, 1, din holds a sample.
REQ-008 SHALL have port din_last, input, 1, qualifies din as the last sample of a row.
REQ-009 SHALL have port din_ready, output, 1, the block accepts din this cycle.
REQ-010 SHALL have port D, output, TILE*DW, the tile; oldest sample at D[49:40], newest at D[9:0].
REQ-011 SHALL have port tile_valid, output, 1, D holds a complete tile.
REQ-012 SHALL have port tile_last, output, 1, the tile closes a row.
REQ-013 SHALL have port tile_ready, input, 1, the downstream Winograd core takes D.

Function
REQ-014 SHALL accept a sample on any edge where din_valid and din_ready are both high.
REQ-015 SHALL shift each accepted sample in at D[9:0] and increment a window count (0..5).
REQ-016 SHALL use states FILL, PAD and HOLD; FILL moves to HOLD on the edge accepting the 5th sample, so tile_valid rises one cycle after that sample.
REQ-017 SHALL drive din_ready = (FILL) or (HOLD and tile_ready and not tile_last); din_ready is low in PAD.
REQ-018 SHALL hold D, tile_valid and tile_last stable in HOLD until tile_ready is high.
REQ-019 SHALL, on a tile handshake with tile_last low, keep the newest 2 samples (overlap TILE-STRIDE) and set count to 2.
REQ-020 SHALL, when a handshake and a sample accept fall on the same edge, shift in the sample, set count to 3 and enter FILL; one tile per 3 cycles is sustained.
REQ-021 SHALL, on a tile handshake with tile_last high, clear the window and count to 0 and enter FILL.
REQ-022 SHALL, when din_last is accepted as the 5th window sample, enter HOLD with tile_last high.
REQ-023 SHALL handle din_last accepted with a resulting count below 5 as set by REQ-027 and REQ-028.
REQ-024 SHALL pass samples unmodified; no arithmetic and no width change.

Reset
REQ-025 SHALL, on rst high, asynchronously clear the window (D=0), count to 0, tile_valid and tile_last to 0, and the state to FILL.
REQ-026 SHALL discard any partial or held tile when rst asserts mid-row; the first tile after release needs 5 fresh samples.

Configuration
REQ-027 SHALL, with macro WC_TILE_PAD_EN defined, enter PAD on a short din_last, shift in one zero per cycle until count is 5, then enter HOLD with tile_last high.
REQ-028 SHALL, without WC_TILE_PAD_EN, drop a short final tile: clear the window and count, stay in FILL, and emit no tile.

Structure
REQ-029 SHALL take DW, TILE, STRIDE and the state enum (FILL, PAD, HOLD) from shared package wc_pkg, which the WC core also uses.
REQ-030 SHALL place the 5-entry shift window in sub-module wc_shift_win, with inputs shift, zero_in and keep2.

Verification
REQ-031 SHALL cover this case: after reset, stream 2,-10,3,4,-13 with tile_ready=1 -> tile_valid high one cycle after -13, D=[2,-10,3,4,-13] (50'b0000000010_1111110110_0000000011_0000000100_1111110011), tile_last=0.
REQ-032 SHALL cover this case: continue -19,-6,3 -> next D=[4,-13,-19,-6,3], tile_valid pulses one cycle after 3, and din_ready never drops.
REQ-033 SHALL cover this case: hold tile_ready=0 for 4 cycles with a tile pending -> D stable, din_ready=0; release -> handshake completes and the overlap of 2 is preserved.
REQ-034 SHALL cover this case: 7 samples 1..7 with din_last on 7 -> with WC_TILE_PAD_EN, tiles [1,2,3,4,5] then [4,5,6,7,0] with tile_last=1; without it, only [1,2,3,4,5] with tile_last=0.
REQ-035 SHALL cover this case: 8 samples 1..8 with din_last on 8 -> second tile [4,5,6,7,8] with tile_last=1, and the next tile needs 5 new samples.
REQ-036 SHALL cover this case: assert rst after 3 samples of a row -> all outputs 0 immediately; the next 5 samples form the first tile.

Source files
------------

// File: rtl/wc_pkg.sv
// Package shared by the tile generator and the Winograd F(3,3) core.
//
// Contents:
//   DW, TILE, STRIDE : default sample width, samples per tile, new samples
//                      per tile after the first.
//   wc_state_t       : tile generator states FILL, PAD, HOLD.
package wc_pkg;

  localparam int DW     = 10;
  localparam int TILE   = 5;
  localparam int STRIDE = 3;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    HOLD = 2'd2
  } wc_state_t;

endpackage

// File: rtl/wc_shift_win.sv
// Five-entry sample window for the F(3,3) tile generator.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset (clears the window).
//   shift    : push one sample in at the newest position (win[DW-1:0]).
//   zero_in  : with shift, push a zero instead of din.
//   keep2    : retain only the newest KEEP samples, zeroing the older ones;
//              applied before a same-cycle shift.
//   clr      : clear the whole window; overrides shift and keep2.
//   din      : sample to push.
//   win      : window contents, oldest sample in the top DW bits.
module wc_shift_win #(
  parameter int DW   = 10,
  parameter int TILE = 5,
  parameter int KEEP = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift,
  input  logic                 zero_in,
  input  logic                 keep2,
  input  logic                 clr,
  input  logic [DW-1:0]        din,
  output logic [TILE*DW-1:0]   win
);

  logic [TILE*DW-1:0] win_q;
  logic [TILE*DW-1:0] win_d;
  logic [TILE*DW-1:0] base;
  logic [DW-1:0]      s_in;

  always_comb begin
    s_in  = zero_in ? '0 : din;
    base  = win_q;
    if (keep2) begin
      base = {{((TILE-KEEP)*DW){1'b0}}, win_q[KEEP*DW-1:0]};
    end
    win_d = base;
    if (shift) begin
      win_d = {base[(TILE-1)*DW-1:0], s_in};
    end
    if (clr) begin
      win_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign win = win_q;

endmodule

// File: rtl/wc_tile_gen.sv
// Tile generator for a Winograd F(3,3) core: slides a 5-sample window over
// each input row with an overlap of 2 and hands out one tile per 3 new
// samples.
//
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset.
//   din        : input sample (two's complement, passed through unmodified).
//   din_valid  : din holds a sample.
//   din_last   : din is the last sample of a row.
//   din_ready  : block accepts din this cycle.
//   D          : tile, oldest sample in the top DW bits, newest in D[DW-1:0].
//   tile_valid : D holds a complete tile.
//   tile_last  : the tile closes a row.
//   tile_ready : downstream core takes D.
//
// Configuration macro:
//   WC_TILE_PAD_EN : a row ending with a partial window is zero-padded to a
//                    full final tile. Undefined: the partial tile is dropped.
module wc_tile_gen #(
  parameter int DW     = wc_pkg::DW,
  parameter int TILE   = wc_pkg::TILE,
  parameter int STRIDE = wc_pkg::STRIDE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        din,
  input  logic                 din_valid,
  input  logic                 din_last,
  output logic                 din_ready,
  output logic [TILE*DW-1:0]   D,
  output logic                 tile_valid,
  output logic                 tile_last,
  input  logic                 tile_ready
);

  import wc_pkg::*;

  localparam int         OVL      = TILE - STRIDE;
  localparam logic [2:0] CNT_FULL = 3'(TILE);
  localparam logic [2:0] CNT_OVL  = 3'(OVL);
  localparam logic [2:0] CNT_OVL1 = 3'(OVL + 1);

  wc_state_t  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       tv_q, tv_d;
  logic       tl_q, tl_d;

  logic       accept;
  logic       take;
  logic [2:0] cnt_new;
  logic       shift, zero_in, keep2, clr;

  // Mid-row handshakes let a new sample in on the same edge so the
  // pipeline sustains one tile per STRIDE cycles; a closing tile does not,
  // because the window must be emptied first.
  assign din_ready = (state_q == FILL) ||
                     ((state_q == HOLD) && tile_ready && !tl_q);
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tv_d    = tv_q;
    tl_d    = tl_q;
    take    = 1'b0;
    cnt_new = cnt_q;
    shift   = 1'b0;
    zero_in = 1'b0;
    keep2   = 1'b0;
    clr     = 1'b0;

    case (state_q)
      FILL: begin
        take    = accept;
        cnt_new = cnt_q + 3'd1;
      end
      PAD: begin
        shift   = 1'b1;
        zero_in = 1'b1;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q + 3'd1 == CNT_FULL) begin
          state_d = HOLD;
          tv_d    = 1'b1;
          tl_d    = 1'b1;
        end
      end
      HOLD: begin
        if (tile_ready) begin
          tv_d    = 1'b0;
          tl_d    = 1'b0;
          state_d = FILL;
          if (tl_q) begin
            clr   = 1'b1;
            cnt_d = '0;
          end else begin
            keep2   = 1'b1;
            cnt_d   = CNT_OVL;
            take    = accept;
            cnt_new = CNT_OVL1;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    // Shared handling of an accepted sample from FILL or a HOLD handshake.
    if (take) begin
      shift = 1'b1;
      cnt_d = cnt_new;
      if (cnt_new == CNT_FULL) begin
        state_d = HOLD;
        tv_d    = 1'b1;
        tl_d    = din_last;
      end else if (din_last) begin
`ifdef WC_TILE_PAD_EN
        state_d = PAD;
`else
        clr     = 1'b1;
        cnt_d   = '0;
        state_d = FILL;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      tv_q    <= 1'b0;
      tl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tv_q    <= tv_d;
      tl_q    <= tl_d;
    end
  end

  wc_shift_win #(
    .DW   (DW),
    .TILE (TILE),
    .KEEP (OVL)
  ) u_win (
    .clk     (clk),
    .rst     (rst),
    .shift   (shift),
    .zero_in (zero_in),
    .keep2   (keep2),
    .clr     (clr),
    .din     (din),
    .win     (D)
  );

  assign tile_valid = tv_q;
  assign tile_last  = tl_q;

endmodule

// File: tb/tb_wc_tile_gen.sv
module tb_wc_tile_gen;

  localparam int DW     = 10;
  localparam int TILE   = 5;
  localparam int STRIDE = 3;
  localparam int TW     = TILE * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_last;
  logic          din_ready;
  logic [TW-1:0] D;
  logic          tile_valid;
  logic          tile_last;
  logic          tile_ready;

  always #5 clk = ~clk;

  wc_tile_gen dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .din_ready  (din_ready),
    .D          (D),
    .tile_valid (tile_valid),
    .tile_last  (tile_last),
    .tile_ready (tile_ready)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [TW-1:0] d;
    logic          last;
    int            need;
    bit            pad;
  } exp_t;

  exp_t expq[$];
  int   row[$];

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: tile k of a row covers samples STRIDE*k .. STRIDE*k+TILE-1;
  // a row ending inside a window is padded with zeros or dropped.
  task automatic build_model(input int L);
    expq.delete();
    for (int k = 0; k < 64; k++) begin
      int   s;
      int   v;
      exp_t e;
      s = STRIDE * k;
      if (s + TILE <= L) begin
        e.d = '0;
        for (int i = 0; i < TILE; i++) e.d = {e.d[TW-DW-1:0], DW'(row[s+i])};
        e.last = (s + TILE == L);
        e.need = s + TILE;
        e.pad  = 1'b0;
        expq.push_back(e);
        if (e.last) break;
      end else begin
`ifdef WC_TILE_PAD_EN
        e.d = '0;
        for (int i = 0; i < TILE; i++) begin
          v   = (s + i < L) ? row[s+i] : 0;
          e.d = {e.d[TW-DW-1:0], DW'(v)};
        end
        e.last = 1'b1;
        e.need = L;
        e.pad  = 1'b1;
        expq.push_back(e);
`endif
        v = 0;
        break;
      end
    end
  endtask

  task automatic load_seq(input int first, input int L);
    row.delete();
    for (int i = 0; i < L; i++) row.push_back(first + i);
  endtask

  task automatic load_rand(input int L);
    row.delete();
    for (int i = 0; i < L; i++) row.push_back(int'($urandom_range(1023)) - 512);
  endtask

  task automatic run_row(input int L, input int vprob, input int rprob, input int stall);
    int            acc;
    int            cyc;
    bit            acc_now;
    bit            prev_hold;
    logic [TW-1:0] prev_d;
    acc       = 0;
    cyc       = 0;
    prev_hold = 1'b0;
    prev_d    = '0;
    build_model(L);
    while ((acc < L || expq.size() > 0) && cyc < 2000) begin
      @(negedge clk);
      din_valid = (acc < L) && ($urandom_range(99) < vprob);
      din       = (acc < L) ? DW'(row[acc]) : '0;
      din_last  = (acc == L - 1);
      if (tile_valid && stall > 0) begin
        tile_ready = 1'b0;
        stall--;
      end else begin
        tile_ready = ($urandom_range(99) < rprob);
      end
      #1;
      if (prev_hold && tile_valid) chk("hold_stable", D, prev_d);
      if (expq.size() == 0) chk("tv_idle", TW'(tile_valid), TW'(1'b0));
      else if (!expq[0].pad) chk("tv_timing", TW'(tile_valid), TW'(acc >= expq[0].need));
      if (tile_valid && expq.size() > 0)
        chk("din_ready_hold", TW'(din_ready), TW'(tile_ready && !expq[0].last));
`ifndef WC_TILE_PAD_EN
      if (!tile_valid) chk("din_ready_fill", TW'(din_ready), TW'(1'b1));
`endif
      if (tile_valid && tile_ready && expq.size() > 0) begin
        chk("tile_D", D, expq[0].d);
        chk("tile_last", TW'(tile_last), TW'(expq[0].last));
        void'(expq.pop_front());
      end
      prev_hold = tile_valid && !tile_ready;
      prev_d    = D;
      acc_now   = din_valid && din_ready;
      @(posedge clk);
      if (acc_now) acc++;
      cyc++;
    end
    if (cyc >= 2000) begin
      checks++;
      errors++;
      $error("FAIL row_timeout observed=%0d accepted expected=%0d", acc, L);
    end
    @(negedge clk);
    din_valid  = 1'b0;
    din_last   = 1'b0;
    tile_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("no_extra_tile", TW'(tile_valid), TW'(1'b0));
      @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    din_last   = 1'b0;
    tile_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_D", D, '0);
    chk("reset_tile_valid", TW'(tile_valid), TW'(1'b0));
    chk("reset_tile_last", TW'(tile_last), TW'(1'b0));
    rst = 1'b0;

    // Signed samples, back-to-back tiles with tile_ready held high.
    row.delete();
    row = '{2, -10, 3, 4, -13, -19, -6, 3, 7, -1, 5};
    run_row(11, 100, 100, 0);

    // Backpressure: first tile stalled for 4 cycles, row of 8 ends exactly.
    load_seq(1, 8);
    run_row(8, 100, 100, 4);

    // Row of 7: short final window.
    load_seq(1, 7);
    run_row(7, 100, 100, 0);

    // Row of 8 without stall; next row must need 5 fresh samples.
    load_seq(1, 8);
    run_row(8, 100, 100, 0);
    load_seq(20, 5);
    run_row(5, 100, 100, 0);

    // Reset in the middle of a row.
    @(negedge clk);
    tile_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din       = DW'(31 + i);
      din_valid = 1'b1;
      din_last  = 1'b0;
      @(negedge clk);
    end
    din_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrow_reset_D", D, '0);
    chk("midrow_reset_tv", TW'(tile_valid), TW'(1'b0));
    chk("midrow_reset_tl", TW'(tile_last), TW'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    load_rand(5);
    run_row(5, 100, 100, 0);

    // Randomized rows, gaps and backpressure.
    for (int r = 0; r < 20; r++) begin
      int L;
      L = int'($urandom_range(20, 1));
      load_rand(L);
      run_row(L, int'($urandom_range(100, 40)), int'($urandom_range(100, 30)), int'($urandom_range(3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
